// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

   localparam int WORD_BYTES        = 4;
   localparam int DEFAULT_IMEM_SIZE = 128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_HALTED,
      ST_FAULT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO; slot 0 is always the head. Accepts a push when full if the
// head is popped in the same cycle.
module fetch_queue #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count,
   output logic             accept
);

   logic [1:0][WIDTH-1:0] slot;
   logic                  do_pop;
   logic                  do_push;

   assign do_pop  = pop && (count != 2'd0);
   assign accept  = (count < 2'd2) || do_pop;
   assign do_push = push && accept;
   assign head    = slot[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot  <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               slot[count[0]] <= push_data;
               count          <= count + 2'd1;
            end
            2'b01: begin
               slot[0] <= slot[1];
               count   <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: new data lands behind whatever remains.
               if (count == 2'd2) begin
                  slot[0] <= slot[1];
                  slot[1] <= push_data;
               end else begin
                  slot[0] <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Sequential instruction fetch with redirect, halt, range/alignment faults
// and a two-entry output queue toward decode.
module fetch_controller
   import cpu_pkg::*;
#(
   parameter int          IMEM_SIZE = DEFAULT_IMEM_SIZE,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   fetch_state_e state;
   logic [31:0]  pc;
   fetch_entry_t entry;
   fetch_entry_t head;
   logic [63:0]  head_raw;
   logic [1:0]   count;
   logic         accept;
   logic         pop;
   logic         push;
   logic         in_range;
   logic         redirect_bad;

   assign imem_addr    = pc;
   assign in_range     = (pc >> 2) <= 32'(IMEM_SIZE - 1);
   assign redirect_bad = redirect_pc[1:0] != 2'b00;
   assign out_valid    = count != 2'd0;
   assign pop          = out_valid && out_ready;
   assign push         = (state == ST_FETCH) && !redirect_valid && !halt
                         && in_range && accept;
   assign entry        = '{pc: pc, instr: imem_instr};
   assign head         = fetch_entry_t'(head_raw);
   assign out_instr    = head.instr;
   assign out_pc       = head.pc;

   fetch_queue #(.WIDTH($bits(fetch_entry_t))) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head_raw),
      .count     (count),
      .accept    (accept)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         fault    <= 1'b0;
         fault_pc <= 32'h0;
      end else if (redirect_valid) begin
         // A misaligned target faults instead of redirecting; pc is left alone.
         if (redirect_bad) begin
            state    <= ST_FAULT;
            fault    <= 1'b1;
            fault_pc <= redirect_pc;
         end else begin
            state <= ST_FETCH;
            pc    <= redirect_pc;
         end
      end else begin
         case (state)
            ST_IDLE: state <= ST_FETCH;
            ST_FETCH: begin
               if (!in_range) begin
                  state    <= ST_FAULT;
                  fault    <= 1'b1;
                  fault_pc <= pc;
               end else if (halt) begin
                  state <= ST_HALTED;
               end else if (accept) begin
                  pc <= pc + 32'(WORD_BYTES);
               end
            end
            ST_HALTED: if (!halt) state <= ST_FETCH;
            ST_FAULT: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter IMEM_SIZE, default 128, meaning instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port imem_addr  output  32  byte address driven to instruction memory read port (combinational read).
REQ-006 Port imem_instr  input  32  instruction word returned for imem_addr in the same cycle.
REQ-007 Port redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-008 Port redirect_pc  input  32  target byte address.
REQ-009 Port halt  input  1  level; stop fetching while high.
REQ-010 Port out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-011 Port out_ready  input  1  decode accepts the head entry this cycle.
REQ-012 Port out_instr  output  32  head instruction.
REQ-013 Port out_pc  output  32  byte address of the head instruction.
REQ-014 Port fault  output  1  sticky fetch fault flag.
REQ-015 Port fault_pc  output  32  address that caused the fault.

Function
REQ-016 State machine SHALL have states IDLE, FETCH, HALTED and FAULT; reset enters IDLE.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH; no enqueue occurs in IDLE.
REQ-018 imem_addr SHALL equal the pc register in every state.
REQ-019 In FETCH, with no redirect, with the queue accepting, and with pc in range: {pc, imem_instr} is enqueued and pc becomes pc+4 (32-bit wrap), giving one instruction per cycle.
REQ-020 The queue is a 2-entry FIFO that accepts when count<2 or a pop occurs in the same cycle (simultaneous push+pop when full is allowed).
REQ-021 When the queue does not accept, pc SHALL hold and no enqueue occurs.
REQ-022 out_valid = queue not empty; a pop occurs when out_valid and out_ready; out_instr and out_pc SHALL stay stable while out_valid and not out_ready.
REQ-023 redirect_valid has the highest priority after reset, in any state:
  - queue flushed (any pop that cycle discarded);
  - no enqueue;
  - pc becomes redirect_pc;
  - next state is FETCH.
REQ-024 A redirect to a misaligned target (redirect_pc[1:0] != 0) SHALL instead:
  - enter FAULT;
  - set fault=1 and fault_pc=redirect_pc;
  - flush the queue.
REQ-025 In FETCH, pc>>2 > IMEM_SIZE-1 SHALL cause entry to FAULT with fault=1 and fault_pc=pc, and no enqueue; already-queued entries still drain.
REQ-026 FAULT SHALL perform no fetches; only an aligned redirect or reset exits it; fault and fault_pc stay sticky until reset.
REQ-027 halt=1 in FETCH (no redirect) SHALL enter HALTED with no enqueue that cycle; queue entries still drain.
REQ-028 HALTED SHALL return to FETCH the cycle after halt=0, resuming at the held pc.
REQ-029 halt and fault conditions in the same cycle: fault wins.

Reset
REQ-030 On reset=0, asynchronously and regardless of clk:
  - pc=RESET_PC;
  - queue empty, so out_valid=0;
  - out_instr=0, out_pc=0;
  - fault=0, fault_pc=0;
  - state=IDLE.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries.

Structure
REQ-032 Package cpu_pkg SHALL hold:
  - the fetch state enum;
  - WORD_BYTES=4;
  - the default IMEM_SIZE constant.
REQ-033 The 2-entry FIFO SHALL be sub-module fetch_queue (parameterized width; push, pop, flush, count).
REQ-034 Target size is 150-300 lines of RTL, with no memory array inside fetch_controller.

Verification
REQ-035 Memory word0=0x00011020, word1=0x00642820, out_ready=1 -> first out_valid 2 cycles after reset release, pc 0x0 then 0x4, one per cycle.
REQ-036 out_ready=0 for 5 cycles -> queue fills at 2 entries, imem_addr holds 0x8, out_instr stays 0x00011020.
REQ-037 redirect_valid with redirect_pc=0x20 while the queue holds 2 entries -> next cycle out_valid=0, following cycle out_pc=0x20.
REQ-038 redirect_pc=0x22 -> fault=1, fault_pc=0x22, no further out_valid until aligned redirect to 0x0 recovers.
REQ-039 IMEM_SIZE=4, sequential run -> entries 0x0..0xC delivered, then fault=1, fault_pc=0x10.
REQ-040 halt pulse for 3 cycles at pc=0x8 -> no enqueue during halt, resume at 0x8; reset asserted mid-run -> out_valid=0 immediately, restart at RESET_PC.
